// File: rtl/pipe_stage_buf.sv
// Elastic pipeline-stage buffer: a DEPTH-entry circular FIFO of {ctrl, data, rd}
// entries. Outputs are forced to zero when no entry is presented, so a bubble reads as a NOP.
module pipe_stage_buf #(
  parameter int CTRL_W = 2,
  parameter int DATA_W = 64,
  parameter int RD_W   = 5,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic [RD_W-1:0]   in_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [RD_W-1:0]   out_rd,
  output logic [CNT_W-1:0]  count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [CTRL_W-1:0] ctrl_mem_q [DEPTH];
  logic [DATA_W-1:0] data_mem_q [DEPTH];
  logic [RD_W-1:0]   rd_mem_q   [DEPTH];

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic push, pop;

  // Valid/ready: a transfer happens on a rising edge where valid and ready are both
  // high. in_ready depends only on registered occupancy (no out_ready -> in_ready path);
  // a source seeing ready low must hold its entry stable until it is accepted.
  assign in_ready  = (count_q < CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Explicit wrap so non-power-of-two depths never reach unused slots.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; the occupancy count alone decides what is live.
  always_ff @(posedge clk) begin
    if (push && !reset && !flush) begin
      ctrl_mem_q[wr_ptr_q] <= in_ctrl;
      data_mem_q[wr_ptr_q] <= in_data;
      rd_mem_q[wr_ptr_q]   <= in_rd;
    end
  end

  assign out_ctrl = out_valid ? ctrl_mem_q[rd_ptr_q] : '0;
  assign out_data = out_valid ? data_mem_q[rd_ptr_q] : '0;
  assign out_rd   = out_valid ? rd_mem_q[rd_ptr_q]   : '0;
  assign count    = count_q;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: three instances (DEPTH 2, 3, 4) share clock and reset;
// one is active at a time and a negedge monitor checks it against an expected queue.
module tb_pipe_stage_buf;

  localparam int EW = 2 + 64 + 5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // index 0: DEPTH=2, index 1: DEPTH=3, index 2: DEPTH=4
  logic        flush     [3];
  logic        in_valid  [3];
  logic        in_ready  [3];
  logic [1:0]  in_ctrl   [3];
  logic [63:0] in_data   [3];
  logic [4:0]  in_rd     [3];
  logic        out_valid [3];
  logic        out_ready [3];
  logic [1:0]  out_ctrl  [3];
  logic [63:0] out_data  [3];
  logic [4:0]  out_rd    [3];
  logic [1:0]  cnt2, cnt3;
  logic [2:0]  cnt4;

  pipe_stage_buf #(.DEPTH(2)) u_d2 (
    .clk(clk), .reset(reset), .flush(flush[0]),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_ctrl(in_ctrl[0]),
    .in_data(in_data[0]), .in_rd(in_rd[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .out_ctrl(out_ctrl[0]), .out_data(out_data[0]),
    .out_rd(out_rd[0]), .count(cnt2)
  );
  pipe_stage_buf #(.DEPTH(3)) u_d3 (
    .clk(clk), .reset(reset), .flush(flush[1]),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_ctrl(in_ctrl[1]),
    .in_data(in_data[1]), .in_rd(in_rd[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .out_ctrl(out_ctrl[1]), .out_data(out_data[1]),
    .out_rd(out_rd[1]), .count(cnt3)
  );
  pipe_stage_buf #(.DEPTH(4)) u_d4 (
    .clk(clk), .reset(reset), .flush(flush[2]),
    .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_ctrl(in_ctrl[2]),
    .in_data(in_data[2]), .in_rd(in_rd[2]), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .out_ctrl(out_ctrl[2]), .out_data(out_data[2]),
    .out_rd(out_rd[2]), .count(cnt4)
  );

  int checks = 0;
  int errors = 0;
  int act = 0;
  logic mon_en = 1'b0;
  logic [EW-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] cnt_of(input int idx);
    case (idx)
      0:       return {2'b00, cnt2};
      1:       return {2'b00, cnt3};
      default: return {1'b0, cnt4};
    endcase
  endfunction

  // Monitor: state seen at negedge is what the next posedge acts on.
  always @(negedge clk) begin
    if (mon_en) begin
      int depth;
      logic [EW-1:0] head, e;
      depth = act + 2;
      head = {out_ctrl[act], out_data[act], out_rd[act]};
      chk("count", 80'(cnt_of(act)), 80'(exp_q.size()));
      chk("in_ready", 80'(in_ready[act]), 80'(exp_q.size() < depth));
      chk("out_valid", 80'(out_valid[act]), 80'(exp_q.size() != 0));
      if (!out_valid[act]) chk("bubble_zero", 80'(head), 80'(0));
      if (reset || flush[act]) begin
        exp_q.delete();
      end else begin
        if (out_valid[act] && out_ready[act]) begin
          if (exp_q.size() == 0) chk("pop_on_empty", 80'(1), 80'(0));
          else begin
            e = exp_q.pop_front();
            chk("head", 80'(head), 80'(e));
          end
        end
        if (in_valid[act] && in_ready[act])
          exp_q.push_back({in_ctrl[act], in_data[act], in_rd[act]});
      end
    end
  end

  task automatic push(input int idx, input logic [1:0] c, input logic [63:0] d,
                      input logic [4:0] r);
    int n;
    n = 0;
    in_valid[idx] = 1'b1;
    in_ctrl[idx]  = c;
    in_data[idx]  = d;
    in_rd[idx]    = r;
    @(negedge clk);
    while (!in_ready[idx] && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) chk("push_timeout", 80'(1), 80'(0));
    @(posedge clk);
    #1;
    in_valid[idx] = 1'b0;
  endtask

  task automatic drain(input int idx);
    int n;
    n = 0;
    out_ready[idx] = 1'b1;
    while (exp_q.size() != 0 && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (n >= 50) chk("drain_timeout", 80'(1), 80'(0));
    @(posedge clk);
    #1;
    out_ready[idx] = 1'b0;
  endtask

  task automatic rst_pulse();
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      flush[i] = 1'b0; in_valid[i] = 1'b0; out_ready[i] = 1'b0;
      in_ctrl[i] = '0; in_data[i] = '0; in_rd[i] = '0;
    end

    // Reset held 2 cycles with a valid entry offered
    act = 0;
    in_valid[0] = 1'b1; in_ctrl[0] = 2'b11; in_rd[0] = 5'd9; in_data[0] = 64'hdead;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    in_valid[0] = 1'b0;
    @(negedge clk);
    chk("rst_count", 80'(cnt2), 80'(0));
    chk("rst_out_valid", 80'(out_valid[0]), 80'(0));
    chk("rst_out_ctrl", 80'(out_ctrl[0]), 80'(0));
    chk("rst_out_rd", 80'(out_rd[0]), 80'(0));
    chk("rst_out_data", 80'(out_data[0]), 80'(0));
    chk("rst_in_ready", 80'(in_ready[0]), 80'(1));
    chk("rst_count_d4", 80'(cnt4), 80'(0));
    mon_en = 1'b1;

    // Stream 1..10 through DEPTH=2 with out_ready high
    @(posedge clk);
    #1 out_ready[0] = 1'b1;
    for (int i = 1; i <= 10; i++) push(0, 2'(i), 64'(i), 5'(i + 3));
    drain(0);

    // Back-pressure to full on DEPTH=2; C waits for out_ready
    rst_pulse();
    push(0, 2'b01, 64'hA, 5'd1);
    push(0, 2'b10, 64'hB, 5'd2);
    fork
      push(0, 2'b11, 64'hC, 5'd3);
      begin
        repeat (3) @(negedge clk);
        chk("bp_count", 80'(cnt2), 80'(2));
        chk("bp_in_ready", 80'(in_ready[0]), 80'(0));
        @(posedge clk);
        #1 out_ready[0] = 1'b1;
      end
    join
    drain(0);

    // Full plus pop on DEPTH=4
    act = 2;
    rst_pulse();
    for (int i = 0; i < 4; i++) push(2, 2'b11, 64'(100 + i), 5'(i));
    @(negedge clk);
    chk("full_count", 80'(cnt4), 80'(4));
    chk("full_in_ready", 80'(in_ready[2]), 80'(0));
    @(posedge clk);
    #1;
    in_valid[2] = 1'b1; in_data[2] = 64'h55; in_rd[2] = 5'd30; out_ready[2] = 1'b1;
    @(posedge clk);
    #1 out_ready[2] = 1'b0;
    @(negedge clk);
    chk("fullpop_count", 80'(cnt4), 80'(3));
    chk("fullpop_in_ready", 80'(in_ready[2]), 80'(1));
    @(posedge clk);
    #1 in_valid[2] = 1'b0;
    drain(2);

    // Flush together with a push of rd=7
    rst_pulse();
    push(2, 2'b11, 64'h11, 5'd4);
    push(2, 2'b11, 64'h22, 5'd5);
    flush[2] = 1'b1;
    in_valid[2] = 1'b1; in_ctrl[2] = 2'b11; in_data[2] = 64'h77; in_rd[2] = 5'd7;
    @(posedge clk);
    #1;
    flush[2] = 1'b0;
    in_valid[2] = 1'b0;
    @(negedge clk);
    chk("flush_count", 80'(cnt4), 80'(0));
    chk("flush_out_valid", 80'(out_valid[2]), 80'(0));
    chk("flush_out_ctrl", 80'(out_ctrl[2]), 80'(0));
    chk("flush_in_ready", 80'(in_ready[2]), 80'(1));
    push(2, 2'b01, 64'h99, 5'd12);
    drain(2);

    // Random push/pop on DEPTH=3
    act = 1;
    rst_pulse();
    for (int i = 0; i < 20; i++) begin
      in_valid[1]  = 1'($urandom_range(0, 1));
      out_ready[1] = 1'($urandom_range(0, 1));
      in_ctrl[1]   = 2'($urandom_range(0, 3));
      in_data[1]   = {32'($urandom), 32'($urandom)};
      in_rd[1]     = 5'($urandom_range(0, 31));
      @(negedge clk);
      chk("d3_count_le3", 80'(cnt3 <= 2'd3), 80'(1));
      @(posedge clk);
      #1;
    end
    in_valid[1] = 1'b0;
    drain(1);

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
